// File: rtl/nco_pkg.sv
// Shared definitions for the NCO / tone measurement blocks.
//   MIDSCALE      : offset-binary zero code of the DAC sample format
//   PERIOD_W_DEF  : default width of the period counter and result
//   LOCK_TOL_DEF  : default max |difference| between consecutive reports for lock
//   meter_state_t : tone_period_meter FSM states
//   zc_class_t    : classification of one sample against the hysteresis band
package nco_pkg;

    localparam int MIDSCALE     = 127;
    localparam int PERIOD_W_DEF = 12;
    localparam int LOCK_TOL_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WAIT_LOW     = 3'd1,
        ST_WAIT_HIGH    = 3'd2,
        ST_MEASURE_LOW  = 3'd3,
        ST_MEASURE_HIGH = 3'd4
    } meter_state_t;

    typedef enum logic [1:0] {
        ZC_BAND = 2'd0,
        ZC_HIGH = 2'd1,
        ZC_LOW  = 2'd2
    } zc_class_t;

endpackage

// File: rtl/zc_hyst_compare.sv
// Combinational hysteresis comparator.
//   sample_in : offset-binary sample (midscale 127)
//   hyst      : hysteresis half-width in codes
//   zc_class  : HIGH above 127+hyst, LOW below 127-hyst, otherwise BAND
module zc_hyst_compare
    import nco_pkg::*;
(
    input  logic [7:0] sample_in,
    input  logic [3:0] hyst,
    output zc_class_t  zc_class
);

    logic [8:0] hi_thr_s;
    logic [8:0] lo_thr_s;

    // Thresholds are computed in 9 bits so 127+15 cannot wrap; 127-15 stays positive.
    always_comb begin
        hi_thr_s = 9'(MIDSCALE) + {5'd0, hyst};
        lo_thr_s = 9'(MIDSCALE) - {5'd0, hyst};
        if ({1'b0, sample_in} > hi_thr_s) begin
            zc_class = ZC_HIGH;
        end else if ({1'b0, sample_in} < lo_thr_s) begin
            zc_class = ZC_LOW;
        end else begin
            zc_class = ZC_BAND;
        end
    end

endmodule

// File: rtl/tone_period_meter.sv
// Measures the period of a tone (in valid samples) between rising crossings
// of a hysteresis band around midscale, optionally averaging groups of four.
//   clk, rst      : clock, synchronous active-high reset
//   sample_in     : offset-binary sample, sample_valid qualifies it
//   hyst          : hysteresis half-width in codes
//   avg_sel       : 0 = report each period, 1 = report mean of 4 periods
//   period        : last reported period
//   period_valid  : one-cycle pulse when period updates
//   locked        : consecutive reports within LOCK_TOL of each other
//   timeout       : one-cycle pulse when no rising crossing arrives in time
module tone_period_meter
    import nco_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int LOCK_TOL = LOCK_TOL_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          sample_in,
    input  logic                sample_valid,
    input  logic [3:0]          hyst,
    input  logic                avg_sel,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                locked,
    output logic                timeout
);

    // The count value at which one more non-crossing sample reaches all-ones.
    localparam logic [PERIOD_W-1:0] CNT_LAST = {{(PERIOD_W-1){1'b1}}, 1'b0};
    localparam logic [PERIOD_W-1:0] CNT_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W-1:0] CNT_ZERO = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W:0]   TOL      = (PERIOD_W+1)'(LOCK_TOL);

    zc_class_t            zc_class_s;
    meter_state_t         state_r, state_s;
    logic [PERIOD_W-1:0]  cnt_r, cnt_s;
    logic [PERIOD_W+1:0]  acc_r, acc_s;
    logic [1:0]           idx_r, idx_s;
    logic                 avg_mode_r, avg_mode_s;
    logic                 have_prev_r, have_prev_s;
    logic [PERIOD_W-1:0]  period_r, period_s;
    logic                 period_valid_r, period_valid_s;
    logic                 locked_r, locked_s;
    logic                 timeout_r, timeout_s;
    logic                 crossing_s;
    logic                 report_s;
    logic                 use_avg_s;
    logic [PERIOD_W-1:0]  raw_s;
    logic [PERIOD_W-1:0]  report_val_s;
    logic [PERIOD_W+1:0]  sum_s;
    logic [PERIOD_W:0]    diff_s;

    zc_hyst_compare u_cmp (
        .sample_in (sample_in),
        .hyst      (hyst),
        .zc_class  (zc_class_s)
    );

    // Next-state, counting, averaging and report/lock decisions.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        acc_s          = acc_r;
        idx_s          = idx_r;
        avg_mode_s     = avg_mode_r;
        have_prev_s    = have_prev_r;
        period_s       = period_r;
        period_valid_s = 1'b0;
        locked_s       = locked_r;
        timeout_s      = 1'b0;
        crossing_s     = 1'b0;
        report_s       = 1'b0;
        use_avg_s      = avg_mode_r;
        raw_s          = cnt_r + CNT_ONE;
        report_val_s   = raw_s;
        sum_s          = acc_r + {2'b00, raw_s};
        diff_s         = {(PERIOD_W+1){1'b0}};

        if (sample_valid) begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_WAIT_LOW;
                    cnt_s   = CNT_ZERO;
                end
                ST_WAIT_LOW: begin
                    if (zc_class_s == ZC_LOW) begin
                        state_s = ST_WAIT_HIGH;
                    end else begin
                        state_s = ST_WAIT_LOW;
                    end
                end
                ST_WAIT_HIGH: begin
                    // First rising crossing only starts the count.
                    if (zc_class_s == ZC_HIGH) begin
                        state_s = ST_MEASURE_HIGH;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = ST_WAIT_HIGH;
                    end
                end
                ST_MEASURE_HIGH, ST_MEASURE_LOW: begin
                    // A crossing on the last countable sample wins over timeout.
                    if ((state_r == ST_MEASURE_LOW) && (zc_class_s == ZC_HIGH)) begin
                        crossing_s = 1'b1;
                        cnt_s      = CNT_ZERO;
                        state_s    = ST_MEASURE_HIGH;
                    end else if (cnt_r == CNT_LAST) begin
                        timeout_s   = 1'b1;
                        locked_s    = 1'b0;
                        acc_s       = {(PERIOD_W+2){1'b0}};
                        idx_s       = 2'd0;
                        have_prev_s = 1'b0;
                        cnt_s       = CNT_ZERO;
                        state_s     = ST_IDLE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                        if (zc_class_s == ZC_LOW) begin
                            state_s = ST_MEASURE_LOW;
                        end else begin
                            state_s = state_r;
                        end
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        // Averaging mode is latched at a group boundary so a group is never mixed.
        if (crossing_s) begin
            if (idx_r == 2'd0) begin
                use_avg_s = avg_sel;
            end else begin
                use_avg_s = avg_mode_r;
            end
            avg_mode_s = use_avg_s;
            if (!use_avg_s) begin
                report_s     = 1'b1;
                report_val_s = raw_s;
            end else if (idx_r == 2'd3) begin
                report_s     = 1'b1;
                report_val_s = sum_s[PERIOD_W+1:2];
                acc_s        = {(PERIOD_W+2){1'b0}};
                idx_s        = 2'd0;
            end else begin
                acc_s = sum_s;
                idx_s = idx_r + 2'd1;
            end
        end else begin
            report_s = 1'b0;
        end

        if (report_val_s >= period_r) begin
            diff_s = {1'b0, report_val_s} - {1'b0, period_r};
        end else begin
            diff_s = {1'b0, period_r} - {1'b0, report_val_s};
        end

        if (report_s) begin
            period_s       = report_val_s;
            period_valid_s = 1'b1;
            locked_s       = have_prev_r && (diff_s <= TOL);
            have_prev_s    = 1'b1;
        end else begin
            period_valid_s = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            cnt_r          <= CNT_ZERO;
            acc_r          <= {(PERIOD_W+2){1'b0}};
            idx_r          <= 2'd0;
            avg_mode_r     <= 1'b0;
            have_prev_r    <= 1'b0;
            period_r       <= CNT_ZERO;
            period_valid_r <= 1'b0;
            locked_r       <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            acc_r          <= acc_s;
            idx_r          <= idx_s;
            avg_mode_r     <= avg_mode_s;
            have_prev_r    <= have_prev_s;
            period_r       <= period_s;
            period_valid_r <= period_valid_s;
            locked_r       <= locked_s;
            timeout_r      <= timeout_s;
        end
    end

    assign period       = period_r;
    assign period_valid = period_valid_r;
    assign locked       = locked_r;
    assign timeout      = timeout_r;

endmodule
